// File: rtl/spi_ram_burst.sv
// spi_ram_burst: SPI slave front end driving an on-chip word-addressed RAM.
// Independent write and read pointers persist across frames. With BURST_EN=1
// a single ss_n frame streams consecutive words, and the pointers auto-increment
// modulo the RAM depth.
//
// Frame format (MSB first on mosi): 2-bit command, then payload.
//   00 WR_ADDR : ADDR_WIDTH bits load wr_ptr
//   01 WR_DATA : DATA_WIDTH-bit words written at wr_ptr
//   10 RD_ADDR : ADDR_WIDTH bits load rd_ptr
//   11 RD_DATA : words from rd_ptr shifted out on miso
//
// Ports:
//   clk   in   serial/system clock, rising-edge
//   rst_n in   asynchronous active-low reset
//   ss_n  in   frame select, active-low
//   mosi  in   serial data in
//   miso  out  serial data out, registered
module spi_ram_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter bit BURST_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic mosi,
    output logic miso
);

    localparam int SW    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW    = $clog2(SW) + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_WR_ADDR = 3'd2,
        S_WR_DATA = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                  state_q,    state_d;
    logic                    cmd_hi_q,   cmd_hi_d;
    logic [CW-1:0]           bit_cnt_q,  bit_cnt_d;
    logic [SW-1:0]           rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q,   rd_ptr_d;
    logic                    miso_q,     miso_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic [DATA_WIDTH-1:0]   mem_rdata_s;
    logic [SW-1:0]           rx_next_s;

    // Receive shift value including the bit sampled on this edge; a word or
    // address completes on the edge that samples its last bit.
    assign rx_next_s   = {rx_shift_q[SW-2:0], mosi};
    assign mem_rdata_s = mem_q[rd_ptr_q];
    assign miso        = miso_q;

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_hi_q   <= 1'b0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_hi_q   <= cmd_hi_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            miso_q     <= miso_d;
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= mem_wdata_s;
        end
    end

    // Next-state and datapath logic. miso defaults to 0 so every state other
    // than RD_DATA, and any edge with ss_n high, drives 0.
    always_comb begin
        state_d     = state_q;
        cmd_hi_d    = cmd_hi_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        miso_d      = 1'b0;
        mem_we_s    = 1'b0;
        mem_wdata_s = rx_next_s[DATA_WIDTH-1:0];

        if (ss_n) begin
            // Frame end: drop any partial word/address, pointers persist.
            state_d    = S_IDLE;
            cmd_hi_d   = 1'b0;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            tx_shift_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_hi_d  = mosi;
                    bit_cnt_d = '0;
                    state_d   = S_CMD;
                end
                S_CMD: begin
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    case ({cmd_hi_q, mosi})
                        2'b00: state_d = S_WR_ADDR;
                        2'b01: state_d = S_WR_DATA;
                        2'b10: state_d = S_RD_ADDR;
                        2'b11: begin
                            // Prefetch the first word so bit 0 can go out next edge.
                            state_d    = S_RD_DATA;
                            tx_shift_d = mem_rdata_s;
                            if (BURST_EN) begin
                                rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                            end else begin
                                rd_ptr_d = rd_ptr_q;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
                S_WR_ADDR, S_RD_ADDR: begin
                    if (bit_cnt_q == CW'(ADDR_WIDTH - 1)) begin
                        if (state_q == S_WR_ADDR) begin
                            wr_ptr_d = rx_next_s[ADDR_WIDTH-1:0];
                        end else begin
                            rd_ptr_d = rx_next_s[ADDR_WIDTH-1:0];
                        end
                        bit_cnt_d  = '0;
                        rx_shift_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        rx_shift_d = rx_next_s;
                    end
                end
                S_WR_DATA: begin
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        mem_we_s   = 1'b1;
                        bit_cnt_d  = '0;
                        rx_shift_d = '0;
                        if (BURST_EN) begin
                            wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bit_cnt_d  = bit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        rx_shift_d = rx_next_s;
                    end
                end
                S_RD_DATA: begin
                    miso_d     = tx_shift_q[DATA_WIDTH-1];
                    tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        if (BURST_EN) begin
                            // Reload on the last-bit edge keeps the stream gapless.
                            tx_shift_d = mem_rdata_s;
                            rd_ptr_d   = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench for spi_ram_burst. Three instances cover the default
// burst configuration, legacy single-word mode, and ADDR_WIDTH=4/DATA_WIDTH=12.
// A small bench-side RAM/pointer model predicts read data; expected words are
// queued when a read frame is issued and popped as the captured bits are sliced.
module tb_spi_ram_burst;

    logic       clk;
    logic       rst_n;
    logic       mosi;
    logic [2:0] ss_n_v;
    logic [2:0] miso_v;

    int total;
    int bad;

    typedef struct {
        logic [31:0] val;
        int          nb;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;
    vec_t vecs[5];

    logic [31:0] mdl [3][256];
    int          wp [3];
    int          rp [3];

    spi_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BURST_EN(1'b1)) u_burst (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n_v[0]), .mosi(mosi), .miso(miso_v[0]));
    spi_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BURST_EN(1'b0)) u_legacy (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n_v[1]), .mosi(mosi), .miso(miso_v[1]));
    spi_ram_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(12), .BURST_EN(1'b1)) u_sweep (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n_v[2]), .mosi(mosi), .miso(miso_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int aw_of(input int sel);
        return (sel == 2) ? 4 : 8;
    endfunction
    function automatic int dw_of(input int sel);
        return (sel == 2) ? 12 : 8;
    endfunction
    function automatic bit burst_of(input int sel);
        return (sel != 1);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Drive one ss_n frame of nbits (tx MSB-aligned at bit nbits-1) and collect
    // miso as seen after edges 2..nbits-1.
    task automatic do_frame(input int sel, input logic [127:0] tx, input int nbits,
                            output logic [127:0] rx);
        rx = '0;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            if (k >= 3) rx = {rx[126:0], miso_v[sel]};
            ss_n_v[sel] = 1'b0;
            mosi = tx[nbits-1-k];
        end
        @(negedge clk);
        if (nbits >= 3) rx = {rx[126:0], miso_v[sel]};
        ss_n_v[sel] = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
    endtask

    task automatic cmd_addr(input int sel, input bit rd, input int addr);
        logic [127:0] tx;
        logic [127:0] rx;
        int a;
        a  = addr % (1 << aw_of(sel));
        tx = (128'(rd ? 2'b10 : 2'b00) << aw_of(sel)) | 128'(a);
        do_frame(sel, tx, 2 + aw_of(sel), rx);
        if (rd) rp[sel] = a;
        else    wp[sel] = a;
    endtask

    task automatic cmd_wr(input int sel, input int n, input logic [31:0] w0,
                          input logic [31:0] w1, input logic [31:0] w2);
        logic [127:0] tx;
        logic [127:0] rx;
        logic [31:0]  w [3];
        logic [31:0]  m;
        int depth;
        depth = 1 << aw_of(sel);
        m = (32'd1 << dw_of(sel)) - 32'd1;
        w[0] = w0 & m; w[1] = w1 & m; w[2] = w2 & m;
        tx = 128'(2'b01);
        for (int i = 0; i < n; i++) begin
            tx = (tx << dw_of(sel)) | 128'(w[i]);
            if (burst_of(sel) || i == 0) mdl[sel][wp[sel]] = w[i];
            if (burst_of(sel)) wp[sel] = (wp[sel] + 1) % depth;
        end
        do_frame(sel, tx, 2 + n * dw_of(sel), rx);
    endtask

    // Read nw words plus 'extra' trailing bits that must be 0.
    task automatic cmd_rd(input int sel, input int nw, input int extra, input string name);
        logic [127:0] tx;
        logic [127:0] rx;
        logic [127:0] sl;
        int p, nbits, pos, depth;
        exp_t e;
        depth = 1 << aw_of(sel);
        p = rp[sel];
        for (int i = 0; i < nw; i++) begin
            sb_q.push_back('{val: mdl[sel][p], nb: dw_of(sel)});
            if (burst_of(sel)) p = (p + 1) % depth;
        end
        if (extra > 0) sb_q.push_back('{val: 32'd0, nb: extra});
        // Burst prefetches one word beyond the last one read.
        if (burst_of(sel)) rp[sel] = (rp[sel] + nw + 1) % depth;
        nbits = 2 + nw * dw_of(sel) + extra;
        tx = 128'(2'b11) << (nbits - 2);
        do_frame(sel, tx, nbits, rx);
        pos = nbits - 2;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            pos = pos - e.nb;
            sl  = (rx >> pos) & ((128'd1 << e.nb) - 128'd1);
            check(name, sl[31:0], e.val);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        mosi = 1'b0;
        ss_n_v = 3'b111;
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            wp[s] = 0;
            rp[s] = 0;
        end
        vecs[0] = '{addr: 8'h10, data: 8'hA5};
        vecs[1] = '{addr: 8'h00, data: 8'h3F};
        vecs[2] = '{addr: 8'h7F, data: 8'h01};
        vecs[3] = '{addr: 8'h80, data: 8'h80};
        vecs[4] = '{addr: 8'h33, data: 8'h5A};

        repeat (3) @(negedge clk);
        check("reset_miso0", {31'd0, miso_v[0]}, 32'd0);
        check("reset_miso1", {31'd0, miso_v[1]}, 32'd0);
        check("reset_miso2", {31'd0, miso_v[2]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of RD_DATA.
        cmd_addr(0, 1'b0, 0);
        cmd_wr(0, 1, 32'hFF, 32'h0, 32'h0);
        cmd_addr(0, 1'b1, 0);
        @(negedge clk); ss_n_v[0] = 1'b0; mosi = 1'b1;
        @(negedge clk); mosi = 1'b1;
        @(negedge clk); mosi = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_read_miso", {31'd0, miso_v[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_miso", {31'd0, miso_v[0]}, 32'd0);
        ss_n_v[0] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            wp[s] = 0;
            rp[s] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmd_rd(0, 1, 0, "post_rst_rd_mem0");
        cmd_wr(0, 1, 32'h5C, 32'h0, 32'h0);
        cmd_addr(0, 1'b1, 0);
        cmd_rd(0, 1, 0, "post_rst_wr_at0");

        // Table-driven single-word write/read pairs.
        foreach (vecs[i]) begin
            cmd_addr(0, 1'b0, int'(vecs[i].addr));
            cmd_wr(0, 1, 32'(vecs[i].data), 32'h0, 32'h0);
        end
        foreach (vecs[i]) begin
            cmd_addr(0, 1'b1, int'(vecs[i].addr));
            cmd_rd(0, 1, 0, "vec_rd");
        end

        // Burst write/read wrapping at the top of the address space.
        cmd_addr(0, 1'b0, 8'hFE);
        cmd_wr(0, 3, 32'h11, 32'h22, 32'h33);
        cmd_addr(0, 1'b1, 8'hFE);
        cmd_rd(0, 3, 0, "wrap_rd");
        cmd_addr(0, 1'b1, 8'h00);
        cmd_rd(0, 1, 0, "wrap_mem0");

        // Aborted write: 5 bits then ss_n high.
        cmd_addr(0, 1'b0, 8'h21);
        cmd_wr(0, 1, 32'h44, 32'h0, 32'h0);
        cmd_addr(0, 1'b0, 8'h21);
        begin
            logic [127:0] rx;
            do_frame(0, {121'd0, 2'b01, 5'b11111}, 7, rx);
        end
        cmd_addr(0, 1'b1, 8'h21);
        cmd_rd(0, 1, 0, "abort_unchanged");
        cmd_wr(0, 1, 32'h99, 32'h0, 32'h0);
        cmd_addr(0, 1'b1, 8'h21);
        cmd_rd(0, 1, 0, "abort_ptr_kept");

        // Legacy single-word mode.
        cmd_addr(1, 1'b0, 8'h06);
        cmd_wr(1, 1, 32'h77, 32'h0, 32'h0);
        cmd_addr(1, 1'b0, 8'h05);
        cmd_wr(1, 2, 32'h3C, 32'hC3, 32'h0);
        cmd_addr(1, 1'b1, 8'h06);
        cmd_rd(1, 1, 0, "legacy_no_2nd_word");
        cmd_addr(1, 1'b1, 8'h05);
        cmd_rd(1, 1, 8, "legacy_rd16");
        cmd_wr(1, 1, 32'h5A, 32'h0, 32'h0);
        cmd_rd(1, 1, 0, "legacy_ptrs_fixed");

        // ADDR_WIDTH=4, DATA_WIDTH=12 with wrap.
        cmd_addr(2, 1'b0, 4'hF);
        cmd_wr(2, 2, 32'hABC, 32'h123, 32'h0);
        cmd_addr(2, 1'b1, 4'hF);
        cmd_rd(2, 2, 0, "sweep_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
